uart_rx_word_assembler: RTL and testbench
=========================================

// Module: uart_rx_word_assembler
// PURPOSE
//  Sequences the UART bit receiver: packs its bit_ready/data_out stream into WIDTH-bit words
//  for the RSA core (key/operand load), and frames messages with the receiver's eot pulse.
//  Double-buffered: assembly continues while the previous word waits on the valid/ready handshake.
// PARAMETERS
//  WIDTH          16   word width in bits, >=8, multiple of 8
//  TIMEOUT_TICKS  192  baud_tick count with no new bit before a partial word is flushed (RX_TIMEOUT_EN only)
// PORTS
//  clk         in   1          system clock
//  rst         in   1          asynchronous reset, active-high
//  baud_tick   in   1          16x oversample strobe shared with the bit receiver
//  bit_ready   in   1          1-cycle strobe: bit_in is valid; not pulsed for bits of the EOT character
//  bit_in      in   1          received data bit, LSB of each byte first
//  eot_in      in   1          1-cycle strobe: EOT character received, message ends
//  word_data   out  WIDTH      output word; first received bit at bit 0; unused upper bits 0
//  word_bits   out  clog2(WIDTH+1)  number of valid bits in word_data (0..WIDTH)
//  word_last   out  1          word closes the message (eot or timeout)
//  word_valid  out  1          output holds a word; stable until accepted
//  word_ready  in   1          consumer accepts when word_valid & word_ready at posedge clk
//  busy        out  1          assembly has >=1 bit, or a word is pending or held
//  overrun     out  1          sticky: bit or eot dropped; cleared by rst or by next accepted word_last
//  timeout     out  1          word_last cause was idle timeout; tied 0 without RX_TIMEOUT_EN
// BEHAVIOUR
//  Reset: all outputs 0, assembly cnt=0, state IDLE.
//  Assembly FSM: IDLE -> COLLECT on first bit_ready; COLLECT -> PEND when cnt reaches WIDTH or eot_in;
//   PEND -> IDLE when the word transfers to the output register.
//  Bit capture: asm[cnt] <= bit_in, cnt++ on bit_ready in IDLE/COLLECT.
//  Transfer: from PEND to output when word_valid=0, or same cycle word_valid&word_ready (zero bubble).
//   Transfer latency 1 clk after the completing bit_ready/eot_in when output is free.
//  eot_in with cnt=0 (IDLE): emit empty word, word_bits=0, word_last=1, word_data=0.
//  eot_in same cycle as WIDTH-th bit: that word gets word_last=1, bits=WIDTH.
//  eot_in same cycle as a non-final bit: bit captured first, word closes with last=1.
//  In PEND: bit_ready dropped, overrun<=1; eot_in latched in pending-eot flag, emitted next as
//   empty last word; second eot_in while flag set: dropped, overrun<=1.
//  Output held (word_valid=1, word_ready=0): word_data/bits/last/timeout must not change.
//  Async rst mid-message: discard all state, no word emitted.
//  baud_tick unused without RX_TIMEOUT_EN.
// CONFIGURATION
//  RX_TIMEOUT_EN defined: in COLLECT, idle counter increments per baud_tick, clears on bit_ready;
//   at TIMEOUT_TICKS closes the partial word as word_last=1, timeout=1; counter inactive in IDLE/PEND.
//  Undefined: no counter; a partial word waits indefinitely for more bits or eot_in; timeout=0.
// STRUCTURE
//  Shared header uart_defs.vh: FSM state localparams (IDLE/COLLECT/PEND), EOT_CHAR=8'h04,
//   OVERSAMPLE=16.
//  Sub-module uart_rx_idle_timer (tick counter, clear, expiry strobe), instantiated only under
//   RX_TIMEOUT_EN.
// TESTING  (bench: clk 10 ns, baud_tick every 10 clk, bit period 160 clk, WIDTH=16)
//  1 bytes 0x9A,0x9B, word_ready=1 -> one word 0x9B9A, bits=16, last=0, valid 1 clk after 16th bit.
//  2 byte 0x1A then eot_in -> word 0x001A, bits=8, last=1; overrun=0.
//  3 eot_in with no prior bits -> word 0x0000, bits=0, last=1.
//  4 word_ready=0, send 0x9A,0x9A,0x9B,0x9B,0x1A -> first word held stable, second in PEND,
//    fifth byte dropped, overrun=1; after word_ready=1, words 0x9A9A then 0x9B9B in order.
//  5 rst pulse after 5 bits of a byte -> all outputs 0, next byte 0x9A assembled from bit 0.
//  6 RX_TIMEOUT_EN, TIMEOUT_TICKS=192: byte 0x9A then idle -> after 192 ticks word 0x009A,
//    bits=8, last=1, timeout=1; without macro, no word emitted within 1000 ticks.

Source files
------------

// File: rtl/uart_rx_word_assembler_pkg.sv
// Shared definitions for the UART receive word assembler: FSM state encoding and
// UART framing constants.
`timescale 1ns/1ps
package uart_rx_word_assembler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PEND    = 2'd2
  } asm_state_e;

  localparam logic [7:0] EOT_CHAR   = 8'h04;
  localparam int         OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_word_assembler_idle_timer.sv
// Idle tick counter that closes a partial word after TICKS baud ticks without a new bit.
// Built only when RX_TIMEOUT_EN is defined.
`timescale 1ns/1ps
`ifdef RX_TIMEOUT_EN
module uart_rx_idle_timer #(
  parameter int TICKS = 192
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int TW = $clog2(TICKS + 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = cnt_q;
    expire_o = 1'b0;
    if (!enable_i || clear_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == TW'(TICKS - 1)) begin
        expire_o = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/uart_rx_word_assembler.sv
// Packs the UART bit receiver stream into WIDTH-bit words with a double-buffered
// valid/ready output. Optional idle-timeout flush is enabled by RX_TIMEOUT_EN.
`timescale 1ns/1ps
module uart_rx_word_assembler
  import uart_rx_word_assembler_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int TIMEOUT_TICKS = 192
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       baud_tick,
  input  logic                       bit_ready,
  input  logic                       bit_in,
  input  logic                       eot_in,
  output logic [WIDTH-1:0]           word_data,
  output logic [$clog2(WIDTH+1)-1:0] word_bits,
  output logic                       word_last,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic                       busy,
  output logic                       overrun,
  output logic                       timeout
);

  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: a word transfers when word_valid & word_ready at posedge clk; while
  // word_valid=1 and word_ready=0 every word_* field is held unchanged.

  asm_state_e     state_q, state_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           pend_last_q, pend_last_d;
  logic           pend_to_q, pend_to_d;
  logic           pend_eot_q, pend_eot_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CW-1:0]  out_bits_q, out_bits_d;
  logic           out_last_q, out_last_d;
  logic           out_to_q, out_to_d;
  logic           out_valid_q, out_valid_d;
  logic           overrun_q, overrun_d;
  logic           accept;
  logic           timer_expire;

`ifdef RX_TIMEOUT_EN
  uart_rx_idle_timer #(
    .TICKS (TIMEOUT_TICKS)
  ) u_idle_timer (
    .clk      (clk),
    .rst      (rst),
    .tick_i   (baud_tick),
    .clear_i  (bit_ready),
    .enable_i (state_q == ST_COLLECT),
    .expire_o (timer_expire)
  );
`else
  logic unused_cfg;
  assign unused_cfg   = baud_tick ^ (TIMEOUT_TICKS > 0);
  assign timer_expire = 1'b0;
`endif

  assign accept = out_valid_q & word_ready;

  always_comb begin
    state_d     = state_q;
    asm_d       = asm_q;
    cnt_d       = cnt_q;
    pend_last_d = pend_last_q;
    pend_to_d   = pend_to_q;
    pend_eot_d  = pend_eot_q;
    out_data_d  = out_data_q;
    out_bits_d  = out_bits_q;
    out_last_d  = out_last_q;
    out_to_d    = out_to_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    if (accept) begin
      out_valid_d = 1'b0;
      if (out_last_q) overrun_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (bit_ready) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q == CW'(i)) asm_d[i] = bit_in;
          end
          cnt_d = cnt_q + 1'b1;
          if ((cnt_q == CW'(WIDTH - 1)) || eot_in) begin
            state_d     = ST_PEND;
            pend_last_d = eot_in;
            pend_to_d   = 1'b0;
          end else begin
            state_d = ST_COLLECT;
          end
        end else if (eot_in) begin
          state_d     = ST_PEND;
          pend_last_d = 1'b1;
          pend_to_d   = 1'b0;
        end else if (timer_expire) begin
          state_d     = ST_PEND;
          pend_last_d = 1'b1;
          pend_to_d   = 1'b1;
        end
      end

      ST_PEND: begin
        if (bit_ready) overrun_d = 1'b1;
        if (!out_valid_q || accept) begin
          out_data_d  = asm_q;
          out_bits_d  = cnt_q;
          out_last_d  = pend_last_q;
          out_to_d    = pend_to_q;
          out_valid_d = 1'b1;
          asm_d       = '0;
          cnt_d       = '0;
          pend_to_d   = 1'b0;
          // A deferred eot becomes an empty last word right behind this one.
          if (pend_eot_q || eot_in) begin
            state_d     = ST_PEND;
            pend_last_d = 1'b1;
            pend_eot_d  = 1'b0;
            if (pend_eot_q && eot_in) overrun_d = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            pend_last_d = 1'b0;
          end
        end else if (eot_in) begin
          if (pend_eot_q) overrun_d  = 1'b1;
          else            pend_eot_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      asm_q       <= '0;
      cnt_q       <= '0;
      pend_last_q <= 1'b0;
      pend_to_q   <= 1'b0;
      pend_eot_q  <= 1'b0;
      out_data_q  <= '0;
      out_bits_q  <= '0;
      out_last_q  <= 1'b0;
      out_to_q    <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      asm_q       <= asm_d;
      cnt_q       <= cnt_d;
      pend_last_q <= pend_last_d;
      pend_to_q   <= pend_to_d;
      pend_eot_q  <= pend_eot_d;
      out_data_q  <= out_data_d;
      out_bits_q  <= out_bits_d;
      out_last_q  <= out_last_d;
      out_to_q    <= out_to_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign word_data  = out_data_q;
  assign word_bits  = out_bits_q;
  assign word_last  = out_last_q;
  assign word_valid = out_valid_q;
  assign busy       = (state_q != ST_IDLE) | out_valid_q;
  assign overrun    = overrun_q;
  assign timeout    = out_to_q;

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// Directed bench for uart_rx_word_assembler: byte framing, eot handling, back-pressure,
// async reset and idle timeout (expectation follows RX_TIMEOUT_EN).
`timescale 1ns/1ps
module tb_uart_rx_word_assembler;

  localparam int WIDTH     = 16;
  localparam int BW        = 5;
  localparam int BIT_CLKS  = 160;
  localparam int TICK_CLKS = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             baud_tick = 1'b0;
  logic             bit_ready = 1'b0;
  logic             bit_in = 1'b0;
  logic             eot_in = 1'b0;
  logic             word_ready = 1'b0;
  logic [WIDTH-1:0] word_data;
  logic [BW-1:0]    word_bits;
  logic             word_last;
  logic             word_valid;
  logic             busy;
  logic             overrun;
  logic             timeout;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  uart_rx_word_assembler #(
    .WIDTH         (WIDTH),
    .TIMEOUT_TICKS (192)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .bit_ready  (bit_ready),
    .bit_in     (bit_in),
    .eot_in     (eot_in),
    .word_data  (word_data),
    .word_bits  (word_bits),
    .word_last  (word_last),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  // clock / baud tick / watchdog
  always #5 clk = ~clk;

  initial begin : tick_gen
    forever begin
      repeat (TICK_CLKS - 1) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // checking
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic send_bit(input logic b, input logic eot);
    repeat (BIT_CLKS - 1) @(negedge clk);
    bit_ready = 1'b1;
    bit_in    = b;
    eot_in    = eot;
    @(negedge clk);
    bit_ready = 1'b0;
    bit_in    = 1'b0;
    eot_in    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic eot_on_last);
    for (int i = 0; i < 8; i++) send_bit(b[i], eot_on_last && (i == 7));
  endtask

  task automatic send_eot();
    repeat (BIT_CLKS - 1) @(negedge clk);
    eot_in = 1'b1;
    @(negedge clk);
    eot_in = 1'b0;
  endtask

  // Word must appear exactly one clock after the closing strobe, then is accepted.
  task automatic expect_word(input string tag, input logic [WIDTH-1:0] d, input int bits,
                             input logic last, input logic to);
    check_eq({tag, ".pre_valid"}, word_valid, 1'b0);
    @(negedge clk);
    check_eq({tag, ".valid"}, word_valid, 1'b1);
    check_eq({tag, ".data"}, word_data, d);
    check_eq({tag, ".bits"}, word_bits, bits);
    check_eq({tag, ".last"}, word_last, last);
    check_eq({tag, ".timeout"}, timeout, to);
    @(negedge clk);
  endtask

  initial begin : main
    int exp_bits[3];
    logic exp_last[3];
    int found;
    int waited;

    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst.valid", word_valid, 1'b0);
    check_eq("rst.data", word_data, 16'h0000);
    check_eq("rst.bits", word_bits, 0);
    check_eq("rst.last", word_last, 1'b0);
    check_eq("rst.busy", busy, 1'b0);
    check_eq("rst.overrun", overrun, 1'b0);
    check_eq("rst.timeout", timeout, 1'b0);
    rst = 1'b0;
    word_ready = 1'b1;

    // 1: two bytes form one full word
    send_byte(8'h9A, 1'b0);
    check_eq("t1.busy_mid", busy, 1'b1);
    send_byte(8'h9B, 1'b0);
    expect_word("t1", 16'h9B9A, 16, 1'b0, 1'b0);
    check_eq("t1.valid_after", word_valid, 1'b0);

    // 2: one byte closed by eot
    send_byte(8'h1A, 1'b0);
    send_eot();
    expect_word("t2", 16'h001A, 8, 1'b1, 1'b0);
    check_eq("t2.overrun", overrun, 1'b0);

    // 3: eot with no bits
    send_eot();
    expect_word("t3", 16'h0000, 0, 1'b1, 1'b0);

    // eot together with the WIDTH-th bit, then with a non-final bit
    send_byte(8'h9A, 1'b0);
    send_byte(8'h9B, 1'b1);
    expect_word("t3b", 16'h9B9A, 16, 1'b1, 1'b0);
    send_byte(8'h1A, 1'b1);
    expect_word("t3c", 16'h001A, 8, 1'b1, 1'b0);
    check_eq("t3c.busy_idle", busy, 1'b0);

    // 4: back-pressure, pending word, dropped byte, deferred eot
    word_ready = 1'b0;
    send_byte(8'h9A, 1'b0);
    send_byte(8'h9A, 1'b0);
    @(negedge clk);
    check_eq("t4.first_valid", word_valid, 1'b1);
    exp_q.push_back(16'h9A9A);
    exp_q.push_back(16'h9B9B);
    exp_q.push_back(16'h0000);
    exp_bits = '{16, 16, 0};
    exp_last = '{1'b0, 1'b0, 1'b1};
    send_byte(8'h9B, 1'b0);
    check_eq("t4.hold_data1", word_data, 16'h9A9A);
    send_byte(8'h9B, 1'b0);
    check_eq("t4.hold_data2", word_data, 16'h9A9A);
    check_eq("t4.overrun_pre", overrun, 1'b0);
    send_byte(8'h1A, 1'b0);
    check_eq("t4.overrun", overrun, 1'b1);
    check_eq("t4.hold_data3", word_data, 16'h9A9A);
    check_eq("t4.hold_bits", word_bits, 16);
    check_eq("t4.hold_last", word_last, 1'b0);
    check_eq("t4.hold_valid", word_valid, 1'b1);
    send_eot();
    check_eq("t4.hold_data4", word_data, 16'h9A9A);
    word_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("t4.w%0d.valid", k), word_valid, 1'b1);
      check_eq($sformatf("t4.w%0d.data", k), word_data, exp_q.pop_front());
      check_eq($sformatf("t4.w%0d.bits", k), word_bits, exp_bits[k]);
      check_eq($sformatf("t4.w%0d.last", k), word_last, exp_last[k]);
      @(negedge clk);
    end
    check_eq("t4.drained", word_valid, 1'b0);
    check_eq("t4.overrun_cleared", overrun, 1'b0);

    // 5: async reset mid-byte
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    check_eq("t5.busy_pre", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_eq("t5.busy_rst", busy, 1'b0);
    check_eq("t5.valid_rst", word_valid, 1'b0);
    check_eq("t5.data_rst", word_data, 16'h0000);
    #1 rst = 1'b0;
    send_byte(8'h9A, 1'b1);
    expect_word("t5", 16'h009A, 8, 1'b1, 1'b0);

    // 6: idle after a partial word
    send_byte(8'h9A, 1'b0);
    found  = 0;
    waited = 0;
    while (!found && waited < 1000 * TICK_CLKS) begin
      @(negedge clk);
      waited++;
      if (word_valid) found = 1;
    end
`ifdef RX_TIMEOUT_EN
    check_eq("t6.found", found, 1);
    check_eq("t6.window", ((waited / TICK_CLKS) >= 190) && ((waited / TICK_CLKS) <= 194), 1'b1);
    check_eq("t6.data", word_data, 16'h009A);
    check_eq("t6.bits", word_bits, 8);
    check_eq("t6.last", word_last, 1'b1);
    check_eq("t6.timeout", timeout, 1'b1);
    @(negedge clk);
`else
    check_eq("t6.no_word", found, 0);
    check_eq("t6.busy", busy, 1'b1);
    send_eot();
    expect_word("t6", 16'h009A, 8, 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
